// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and constants for the sequential divider
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } div_state_t;

    localparam int          DIV_ITER   = 32;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    // Two's-complement negate when en is set; also used for magnitude capture
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/adder32.sv
// rtl/adder32.sv - 32-bit adder with carry in/out
module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

// File: rtl/divider32.sv
// rtl/divider32.sv - sequential restoring divider, one quotient bit per clock
module divider32
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam logic [4:0] LAST_ITER = 5'(DIV_ITER - 1);

    div_state_t       state;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dsr;
    logic [4:0]       cnt;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             carry;
    logic             qbit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;

    assign shifted = {rem, dvd[WIDTH-1]};

    adder32 u_sub (
        .a    (shifted[WIDTH-1:0]),
        .b    (~dsr),
        .cin  (1'b1),
        .sum  (diff),
        .cout (carry)
    );

    // shifted[WIDTH] set means the 33-bit value already exceeds any 32-bit divisor
    assign qbit     = carry | shifted[WIDTH];
    assign rem_next = qbit ? diff : shifted[WIDTH-1:0];
    assign quo_next = {dvd[WIDTH-2:0], qbit};

    assign dividend_mag = neg_if(dividend, sign & dividend[WIDTH-1]);
    assign divisor_mag  = neg_if(divisor,  sign & divisor[WIDTH-1]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            dvd       <= '0;
            rem       <= '0;
            dsr       <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_FIN: begin
                    if (start) begin
                        dvd      <= dividend_mag;
                        dsr      <= divisor_mag;
                        rem      <= '0;
                        cnt      <= '0;
                        neg_q    <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r    <= sign & dividend[WIDTH-1];
                        div_zero <= 1'b0;
                        if (divisor == '0) begin
                            state     <= ST_FIN;
                            done      <= 1'b1;
                            div_zero  <= 1'b1;
                            quotient  <= DIV_ZERO_Q;
                            remainder <= dividend;
                        end else begin
                            state <= ST_CALC;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    dvd <= quo_next;
                    rem <= rem_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST_ITER) begin
                        state     <= ST_FIN;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= neg_if(quo_next, neg_q);
                        remainder <= neg_if(rem_next, neg_r);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider32.sv
// tb/tb_divider32.sv - randomized self-checking bench for divider32
module tb_divider32;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        sign = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int checks = 0;
    int errors = 0;

    divider32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .sign      (sign),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_q(input logic s, input logic [31:0] a, input logic [31:0] b);
        if (!s) return a / b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
    endfunction

    function automatic logic [31:0] ref_r(input logic s, input logic [31:0] a, input logic [31:0] b);
        if (!s) return a % b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
    endfunction

    // Transaction-level model: a countdown of remaining busy cycles and pending results
    int          m_left;
    logic        m_done;
    logic        m_dz;
    logic [31:0] m_q;
    logic [31:0] m_r;
    logic [31:0] p_q;
    logic [31:0] p_r;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            p_q    <= '0;
            p_r    <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_q    <= p_q;
                    m_r    <= p_r;
                end
            end else if (start) begin
                if (divisor == 32'd0) begin
                    m_done <= 1'b1;
                    m_dz   <= 1'b1;
                    m_q    <= 32'hFFFF_FFFF;
                    m_r    <= dividend;
                end else begin
                    m_left <= 32;
                    m_dz   <= 1'b0;
                    p_q    <= ref_q(sign, dividend, divisor);
                    p_r    <= ref_r(sign, dividend, divisor);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy",      {31'd0, busy},     {31'd0, m_left > 0});
        chk("done",      {31'd0, done},     {31'd0, m_done});
        chk("div_zero",  {31'd0, div_zero}, {31'd0, m_dz});
        chk("quotient",  quotient,          m_q);
        chk("remainder", remainder,         m_r);
    end

    // One directed command; pins latency, busy length, results and the model itself
    task automatic do_op(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz, input int elat);
        int lat;
        int nbusy;
        @(posedge clk); #1;
        start = 1'b1; sign = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        nbusy = 0;
        while (!done && lat < 100) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_lat"},   lat,               elat);
        chk({nm, "_nbusy"}, nbusy,             (elat == 1) ? 0 : 32);
        chk({nm, "_q"},     quotient,          eq);
        chk({nm, "_r"},     remainder,         er);
        chk({nm, "_dz"},    {31'd0, div_zero}, {31'd0, edz});
        chk({nm, "_mq"},    m_q,               eq);
        chk({nm, "_mr"},    m_r,               er);
    endtask

    initial begin
        int lat;
        int ops;
        logic [31:0] first_q;
        logic [31:0] first_r;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_q",    quotient,      32'd0);
        chk("rst_r",    remainder,     32'd0);
        resetn = 1'b1;

        do_op("u100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33);
        do_op("s_m7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33);
        do_op("s_7_m2",   1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 33);
        do_op("u_dz",     1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1);
        do_op("s_dz",     1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1);
        do_op("u_max_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33);
        do_op("u_max_m1", 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          32'd1,          1'b0, 33);
        do_op("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33);

        // start while busy must be ignored
        @(posedge clk); #1;
        start = 1'b1; sign = 1'b0; dividend = 32'd1000; divisor = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; dividend = 32'd5; divisor = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 11;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("busy_start_lat", lat,       33);
        chk("busy_start_q",   quotient,  32'd111);
        chk("busy_start_r",   remainder, 32'd1);
        first_q = quotient;
        first_r = remainder;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_q", quotient,  first_q);
        chk("hold_r", remainder, first_r);

        // reset in the middle of an iteration
        @(posedge clk); #1;
        start = 1'b1; sign = 1'b1; dividend = 32'd77; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_q",    quotient,      32'd0);
        chk("midrst_r",    remainder,     32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (40) @(posedge clk);
        do_op("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);

        // random back-to-back regression; the compare process checks every cycle
        ops = 0;
        @(posedge clk); #1;
        while (ops < 1000) begin
            start    = 1'b1;
            sign     = 1'($urandom_range(0, 1));
            dividend = $urandom;
            case ($urandom_range(0, 31))
                0:       divisor = 32'd0;
                1:       divisor = 32'hFFFF_FFFF;
                2:       divisor = $urandom_range(1, 15);
                default: divisor = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 31) == 0) dividend = 32'h8000_0000;
            @(posedge clk); #1;
            start = 1'b0;
            lat = 1;
            while (!done && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            if (!done) begin
                chk("rand_timeout", lat, 33);
                break;
            end
            ops++;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
